// File: rtl/add_wb_stage.sv
// add_wb_stage: writeback stage behind the rec_dub adder.
// It tracks destination tags through the adder's fixed latency and captures
// {tag, sum, cout} when each result emerges. Results are buffered in order and
// presented on a registered valid/ready head.
// A credit counter gates issue, so the buffer cannot overflow.
// Optional feature macro: ADD_WB_ZERO_FLAG_EN adds the wb_zero output.
module add_wb_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LAT   = 2,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             issue_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_tag,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_carry,
`ifdef ADD_WB_ZERO_FLAG_EN
  output logic             wb_zero,
`endif
  output logic             busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
    logic             carry;
`ifdef ADD_WB_ZERO_FLAG_EN
    logic             zero;
`endif
  } entry_t;

  // Tag pipeline that shadows the adder
  logic [LAT-1:0]   pipe_vld;
  logic [TAG_W-1:0] pipe_tag [LAT];

  // Storage behind the registered head
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] st_cnt;

  // Head register and credits
  entry_t           head;
  logic             head_vld;
  logic [CNT_W-1:0] cnt;
  logic             room;

  // Combinational control
  logic             accept_c;
  logic             push_c;
  logic             pop_c;
  logic             head_load_c;
  logic             st_pop_c;
  logic             head_from_push_c;
  logic             st_push_c;
  logic [CNT_W-1:0] cnt_next_c;
  entry_t           new_entry_c;

  // Handshake decode, capture payload and credit next value
  always_comb begin
    accept_c         = issue_valid && issue_ready;
    push_c           = pipe_vld[LAT-1];
    pop_c            = head_vld && wb_ready;
    head_load_c      = !head_vld || pop_c;
    st_pop_c         = head_load_c && (st_cnt != '0);
    head_from_push_c = head_load_c && (st_cnt == '0) && push_c;
    st_push_c        = push_c && !head_from_push_c;

    new_entry_c       = '0;
    new_entry_c.tag   = pipe_tag[LAT-1];
    new_entry_c.data  = sum;
    new_entry_c.carry = cout;
`ifdef ADD_WB_ZERO_FLAG_EN
    new_entry_c.zero  = ({cout, sum} == '0);
`endif

    cnt_next_c = cnt;
    case ({accept_c, pop_c})
      2'b10:   cnt_next_c = cnt + CNT_W'(1);
      2'b01:   cnt_next_c = cnt - CNT_W'(1);
      default: cnt_next_c = cnt;
    endcase
  end

  // Shift {valid, tag} down the adder-latency pipeline every edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_vld[0] <= accept_c;
      pipe_tag[0] <= issue_tag;
      for (int i = 1; i < LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  // Storage write; contents need no reset since pointers gate every read
  always_ff @(posedge clk) begin
    if (st_push_c) mem[wr_ptr] <= new_entry_c;
  end

  // Head refill: from storage first, else directly from the capture
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      head_vld <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      st_cnt   <= '0;
    end else begin
      if (head_load_c) begin
        if (st_pop_c) begin
          head     <= mem[rd_ptr];
          head_vld <= 1'b1;
        end else if (head_from_push_c) begin
          head     <= new_entry_c;
          head_vld <= 1'b1;
        end else begin
          head_vld <= 1'b0;
        end
      end
      if (st_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (st_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({st_push_c, st_pop_c})
        2'b10:   st_cnt <= st_cnt + CNT_W'(1);
        2'b01:   st_cnt <= st_cnt - CNT_W'(1);
        default: st_cnt <= st_cnt;
      endcase
    end
  end

  // Credit counter and registered room flag; no path from wb_ready to issue_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      room <= 1'b1;
    end else begin
      cnt  <= cnt_next_c;
      room <= (cnt_next_c < CNT_W'(DEPTH));
    end
  end

  // Credits bound the total of in-flight plus buffered entries
  always_ff @(posedge clk) begin
    if (!rst) assert (cnt <= CNT_W'(DEPTH));
  end

  assign issue_ready = !rst && room;
  assign busy        = (cnt != '0);
  assign wb_valid    = head_vld;
  assign wb_tag      = head.tag;
  assign wb_data     = head.data;
  assign wb_carry    = head.carry;
`ifdef ADD_WB_ZERO_FLAG_EN
  assign wb_zero     = head.zero;
`endif

endmodule

// File: tb/tb_add_wb_stage.sv
// Testbench for add_wb_stage: randomized and directed stimulus checked against
// a queue-based model of issue, capture and in-order writeback.
module tb_add_wb_stage;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LAT   = 2;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic [TAG_W-1:0] issue_tag;
  logic             issue_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             wb_valid;
  logic             wb_ready;
  logic [TAG_W-1:0] wb_tag;
  logic [WIDTH-1:0] wb_data;
  logic             wb_carry;
  logic             busy;
`ifdef ADD_WB_ZERO_FLAG_EN
  logic             wb_zero;
`endif

  add_wb_stage #(.WIDTH(WIDTH), .LAT(LAT), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_ready(issue_ready),
    .sum(sum), .cout(cout),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_tag(wb_tag), .wb_data(wb_data), .wb_carry(wb_carry),
`ifdef ADD_WB_ZERO_FLAG_EN
    .wb_zero(wb_zero),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int tag; int due; } infl_t;
  typedef struct { logic [TAG_W-1:0] tag; logic [WIDTH-1:0] data; logic carry; } res_t;

  infl_t       infl_q[$];
  res_t        out_q[$];
  logic [32:0] res_q[$];   // the bench plays the adder: results LAT cycles after operands
  int          cyc = 0;
  bit          model_ok = 0;
  bit          zero_since_rst = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, compare DUT to model, advance model, cross the edge
  task automatic cycle(input logic r, input logic iv, input int tag,
                       input logic [31:0] a, input logic [31:0] b, input logic wr);
    int   mcnt;
    bit   pop, acc;
    res_t e;
    rst         = r;
    issue_valid = iv;
    issue_tag   = TAG_W'(tag);
    wb_ready    = wr;
    res_q.push_back({1'b0, a} + {1'b0, b});
    if (res_q.size() > LAT) {cout, sum} = res_q.pop_front();
    else {cout, sum} = {1'b0, $urandom()};
    #1;
    mcnt = infl_q.size() + out_q.size();
    if (model_ok) begin
      chk("issue_ready", 64'(issue_ready), 64'(!r && (mcnt < DEPTH)));
      chk("busy", 64'(busy), 64'(mcnt != 0));
      chk("wb_valid", 64'(wb_valid), 64'(out_q.size() != 0));
      if (out_q.size() != 0) begin
        chk("wb_tag", 64'(wb_tag), 64'(out_q[0].tag));
        chk("wb_data", 64'(wb_data), 64'(out_q[0].data));
        chk("wb_carry", 64'(wb_carry), 64'(out_q[0].carry));
`ifdef ADD_WB_ZERO_FLAG_EN
        chk("wb_zero", 64'(wb_zero), 64'({out_q[0].carry, out_q[0].data} == 33'd0));
`endif
      end else if (zero_since_rst) begin
        chk("reset_head", 64'({wb_tag, wb_data, wb_carry}), 64'd0);
      end
    end
    if (r) begin
      infl_q.delete();
      out_q.delete();
      model_ok = 1;
      zero_since_rst = 1;
    end else begin
      pop = (out_q.size() != 0) && wr;
      acc = iv && (mcnt < DEPTH);
      if (pop) void'(out_q.pop_front());
      if (infl_q.size() != 0 && infl_q[0].due == cyc) begin
        e.tag = TAG_W'(infl_q[0].tag);
        e.data = sum;
        e.carry = cout;
        out_q.push_back(e);
        void'(infl_q.pop_front());
        zero_since_rst = 0;
      end
      if (acc) infl_q.push_back('{tag, cyc + LAT});
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, $urandom(), $urandom(), 1'b1);
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_tag = '0; wb_ready = 1'b0; sum = '0; cout = 1'b0;
    @(negedge clk);

    // Reset with issue_valid held high
    cycle(1'b1, 1'b1, 3, 1, 1, 1'b0);
    cycle(1'b1, 1'b1, 3, 1, 1, 1'b0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_head", 64'({wb_tag, wb_data, wb_carry}), 64'd0);
    cycle(1'b0, 1'b0, 0, 0, 0, 1'b1);
    chk("ready_after_rst", 64'(issue_ready), 64'd1);

    // Carry case
    cycle(1'b0, 1'b1, 5, 32'd4139379753, 32'd4043304975, 1'b0);
    cycle(1'b0, 1'b0, 0, 0, 0, 1'b0);
    chk("carry_not_early", 64'(wb_valid), 64'd0);
    cycle(1'b0, 1'b0, 0, 0, 0, 1'b0);
    chk("carry_valid", 64'(wb_valid), 64'd1);
    chk("carry_tag", 64'(wb_tag), 64'd5);
    chk("carry_data", 64'(wb_data), 64'd3887717432);
    chk("carry_cout", 64'(wb_carry), 64'd1);
    idle(2);

    // No-carry cases
    cycle(1'b0, 1'b1, 7, 32'd885995213, 32'd2626620523, 1'b0);
    cycle(1'b0, 1'b1, 9, 32'd1200, 32'd1000, 1'b0);
    cycle(1'b0, 1'b0, 0, 0, 0, 1'b0);
    chk("nc_tag", 64'(wb_tag), 64'd7);
    chk("nc_data", 64'(wb_data), 64'd3512615736);
    chk("nc_cout", 64'(wb_carry), 64'd0);
    cycle(1'b0, 1'b0, 0, 0, 0, 1'b1);
    chk("small_tag", 64'(wb_tag), 64'd9);
    chk("small_data", 64'(wb_data), 64'd2200);
    idle(3);

    // Backpressure: fill all credits, hold off a fifth issue, then drain
    for (int t = 1; t <= 4; t++) cycle(1'b0, 1'b1, t, $urandom(), $urandom(), 1'b0);
    chk("bp_ready_low", 64'(issue_ready), 64'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 5, $urandom(), $urandom(), 1'b0);
    chk("bp_head_tag", 64'(wb_tag), 64'd1);
    cycle(1'b0, 1'b0, 0, 0, 0, 1'b1);
    chk("bp_pop_tag", 64'(wb_tag), 64'd2);
    chk("bp_ready_back", 64'(issue_ready), 64'd1);
    idle(4);
    chk("bp_drained", 64'(busy), 64'd0);

    // Sustained one issue per cycle with no bubbles
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, i + 10, $urandom(), $urandom(), 1'b1);
      if (i >= LAT) chk("no_bubble", 64'(wb_valid), 64'd1);
    end
    idle(4);

    // Reset pulsed one cycle before the first capture
    cycle(1'b0, 1'b1, 20, $urandom(), $urandom(), 1'b1);
    cycle(1'b0, 1'b1, 21, $urandom(), $urandom(), 1'b1);
    cycle(1'b1, 1'b0, 0, 0, 0, 1'b1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_valid", 64'(wb_valid), 64'd0);
    idle(4);

`ifdef ADD_WB_ZERO_FLAG_EN
    cycle(1'b0, 1'b1, 3, 0, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 0, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 0, 0, 1'b0);
    chk("zero_set", 64'(wb_zero), 64'd1);
    cycle(1'b0, 1'b1, 4, 32'h8000_0000, 32'h8000_0000, 1'b1);
    cycle(1'b0, 1'b0, 0, 0, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 0, 0, 1'b0);
    chk("zero_clr", 64'(wb_zero), 64'd0);
    chk("zero_clr_carry", 64'(wb_carry), 64'd1);
    chk("zero_clr_data", 64'(wb_data), 64'd0);
    idle(3);
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 500; i++)
      cycle(1'($urandom_range(99) < 2), 1'($urandom_range(99) < 70), int'($urandom_range(31)),
            $urandom(), $urandom(), 1'($urandom_range(99) < 60));
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/add_wb_stage.md
Name: add_wb_stage

Overview:
- Downstream writeback stage for the 32-bit recursive-doubling adder (`rec_dub`) in the VLIW ALU slot.
- Tracks each issued add through the adder's fixed pipeline latency, using a destination tag.
- Captures sum and carry-out when the result emerges and buffers it in a small in-order FIFO.
- Presents results to the register-file write port through a valid/ready handshake.
- Credit-based issue_ready guarantees the FIFO never overflows.

Parameters:
WIDTH, 32, adder data width (sum width; carry is separate)
LAT, 2, adder latency in clock edges from issue to result; legal range 1..8
TAG_W, 5, destination-register tag width
DEPTH, 4, result FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
issue_valid  input  1  an add is being issued to the adder this cycle
issue_tag  input  TAG_W  destination tag of the issued add
issue_ready  output  1  stage can accept an issue this cycle
sum  input  WIDTH  adder sum output
cout  input  1  adder carry-out
wb_valid  output  1  FIFO head holds a result
wb_ready  input  1  register file accepts the head this cycle
wb_tag  output  TAG_W  destination tag of the head
wb_data  output  WIDTH  sum of the head
wb_carry  output  1  carry of the head
busy  output  1  any entry in flight or buffered

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high. Every state element updates only on the rising edge of `clk`.
- Reset state: all in-flight valid bits = 0, FIFO pointers = 0, occupancy count = 0. Outputs: wb_valid = 0, wb_tag = 0, wb_data = 0, wb_carry = 0, busy = 0.
- issue_ready is forced to 0 while rst is high.
- Accept: an issue is accepted at an edge when issue_valid && issue_ready are both high in the preceding cycle. The caller launches operands into the adder in that same cycle.
- Tag pipeline: LAT-stage shift register of {valid, tag}, advancing every edge with no stall. The adder never stalls; all backpressure is absorbed by the credits.
- Capture: an entry accepted at edge k is pushed into the FIFO at edge k+LAT. The pushed values are {tag, sum, cout} as sampled just before that edge.
- Writeback timing: wb_valid rises after edge k+LAT, so minimum issue-to-writeback latency is LAT edges. There is no bypass from sum to wb_data.
- Pop: the head is popped at an edge when wb_valid && wb_ready. The next entry (if any) appears on wb_* after that edge.
- Head hold: while wb_ready = 0, all wb_* outputs hold stable.
- Ordering: strict in-order; results leave in issue order.
- Credits: count = in-flight entries + FIFO entries, held as one registered counter.
  - +1 on accept, -1 on pop; no change when both occur at the same edge.
  - issue_ready = !rst && (count < DEPTH). This is a registered comparison with no combinational path from wb_ready.
- Pointers wrap modulo DEPTH. A push into a full FIFO and a pop from an empty FIFO are both impossible by construction. Assertion: count never exceeds DEPTH.
- busy = (count != 0).
- Width rules: sum is WIDTH bits and cout is the separate bit WIDTH. {wb_carry, wb_data} equals the full WIDTH+1-bit result.
- Reset mid-operation: asserting rst for one cycle discards all in-flight and buffered entries; none is ever presented on wb_*. issue_ready returns to 1 in the first cycle after rst deasserts.

Optional Feature:
- Macro: ADD_WB_ZERO_FLAG_EN.
- When defined: adds output port `wb_zero` (1 bit), registered alongside the FIFO entry. wb_zero = 1 iff {cout, sum} == 0 at capture; it resets to 0.
- When undefined: the port and the extra FIFO bit are absent; all other behaviour is identical.

Test Plan:
- Reset: rst high for 2 cycles with issue_valid=1 -> issue_ready=0 and wb_valid=0 throughout, no accept; busy=0; issue_ready=1 the cycle after release.
- Carry case (LAT=2): issue tag 5 with sum=3887717432, cout=1 (from 4139379753+4043304975) -> exactly 2 edges later wb_valid=1, wb_tag=5, wb_data=3887717432, wb_carry=1.
- No-carry case: issue tag 7 with sum=3512615736, cout=0 (from 885995213+2626620523) -> wb_data=3512615736, wb_carry=0; issue tag 9 with sum=2200 (from 1200+1000) -> wb_data=2200.
- Backpressure: wb_ready=0, issue tags 1,2,3,4 back-to-back -> issue_ready=0 after 4th accept, 5th held off. Then wb_ready=1 -> tags 1,2,3,4 leave one per cycle in order; issue_ready=1 the cycle after the first pop.
- Simultaneous accept+pop at count=3 (DEPTH=4) -> count stays 3, issue_ready stays 1. Sustained 1 issue/cycle with wb_ready=1 runs with no bubbles.
- Reset mid-flight: 2 accepted entries, rst pulsed 1 cycle before capture -> wb_valid never rises for them, busy=0 after the edge. With ADD_WB_ZERO_FLAG_EN: {cout,sum}={0,0} -> wb_zero=1; {1,0} (2^31+2^31) -> wb_zero=0.
